// File: rtl/eth_tx_framer_if.sv
// Upstream nibble stream, MII transmit outputs and CRC calculator hookup for eth_tx_framer.
// slave  : the framer (consumes IN_*, drives OUT_*)
// master : the environment (upstream source, CRC block, MII sink)
// Signals:
//   IN_VALID/IN_DATA/IN_LAST/OUT_READY : upstream nibble handshake
//   OUT_TXEN/OUT_TXD                   : MII transmit nibble
//   OUT_CRC_CLR/ENA/DATA, IN_CRC       : external CRC-32 nibble calculator
//   OUT_BUSY/OUT_UNDERRUN              : status
interface eth_tx_framer_if;
    logic        IN_VALID;
    logic [3:0]  IN_DATA;
    logic        IN_LAST;
    logic        OUT_READY;
    logic        OUT_TXEN;
    logic [3:0]  OUT_TXD;
    logic        OUT_CRC_CLR;
    logic        OUT_CRC_ENA;
    logic [3:0]  OUT_CRC_DATA;
    logic [31:0] IN_CRC;
    logic        OUT_BUSY;
    logic        OUT_UNDERRUN;

    modport master (
        output IN_VALID, IN_DATA, IN_LAST, IN_CRC,
        input  OUT_READY, OUT_TXEN, OUT_TXD, OUT_CRC_CLR, OUT_CRC_ENA,
               OUT_CRC_DATA, OUT_BUSY, OUT_UNDERRUN
    );

    modport slave (
        input  IN_VALID, IN_DATA, IN_LAST, IN_CRC,
        output OUT_READY, OUT_TXEN, OUT_TXD, OUT_CRC_CLR, OUT_CRC_ENA,
               OUT_CRC_DATA, OUT_BUSY, OUT_UNDERRUN
    );
endinterface

// File: rtl/eth_tx_framer.sv
// MII transmit framer: preamble/SFD, payload, zero pad to minimum size, FCS, inter-frame gap.
// Ports:
//   CLK   : clock, one nibble per cycle
//   RESET : synchronous, active-high
//   bus   : eth_tx_framer_if.slave (upstream stream, MII outputs, external CRC hookup)
// OUT_TXEN/OUT_TXD/OUT_UNDERRUN are registered; OUT_READY, OUT_BUSY and OUT_CRC_CLR
// decode the state register; OUT_CRC_ENA/OUT_CRC_DATA follow IN_VALID/IN_DATA in DATA.
module eth_tx_framer #(
    parameter int unsigned PREAMBLE_NIBBLES = 15,
    parameter int unsigned MIN_NIBBLES      = 120,
    parameter int unsigned IFG_NIBBLES      = 24
) (
    input  logic           CLK,
    input  logic           RESET,
    eth_tx_framer_if.slave bus
);

    localparam int unsigned NIB_W       = 12;
    localparam int unsigned FCS_NIBBLES = 8;
    localparam int unsigned CNT_MAX0    = (IFG_NIBBLES > PREAMBLE_NIBBLES) ? IFG_NIBBLES
                                                                           : PREAMBLE_NIBBLES;
    localparam int unsigned CNT_MAX     = (CNT_MAX0 > FCS_NIBBLES) ? CNT_MAX0 : FCS_NIBBLES;
    localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);

    localparam logic [NIB_W-1:0] NIB_SAT = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_PAD,
        S_FCS,
        S_IFG
    } state_e;

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [NIB_W-1:0] nib_cnt_q,  nib_cnt_d;
    logic [31:0]      fcs_q,      fcs_d;
    logic             txen_q,     txen_d;
    logic [3:0]       txd_q,      txd_d;
    logic             underrun_q, underrun_d;

    logic             crc_ena_c;
    logic [3:0]       crc_data_c;
    logic [NIB_W-1:0] nib_inc_c;
    logic [31:0]      fcs_word_c;
    logic [3:0]       fcs_slice_c;
    logic [3:0]       fcs_nib_c;

    // Saturating payload nibble count after one more nibble.
    assign nib_inc_c = (nib_cnt_q == NIB_SAT) ? nib_cnt_q : nib_cnt_q + NIB_W'(1);

    // The CRC result is live on the first FCS cycle; later nibbles come from the snapshot.
    assign fcs_word_c = (cnt_q == '0) ? bus.IN_CRC : fcs_q;

    // FCS nibble k takes C[31-4k] onto TXD[0], so each 4-bit slice goes out bit-reversed.
    always_comb begin
        fcs_slice_c = fcs_word_c[31:28];
        unique case (cnt_q[2:0])
            3'd0:    fcs_slice_c = fcs_word_c[31:28];
            3'd1:    fcs_slice_c = fcs_word_c[27:24];
            3'd2:    fcs_slice_c = fcs_word_c[23:20];
            3'd3:    fcs_slice_c = fcs_word_c[19:16];
            3'd4:    fcs_slice_c = fcs_word_c[15:12];
            3'd5:    fcs_slice_c = fcs_word_c[11:8];
            3'd6:    fcs_slice_c = fcs_word_c[7:4];
            3'd7:    fcs_slice_c = fcs_word_c[3:0];
            default: fcs_slice_c = fcs_word_c[31:28];
        endcase
        fcs_nib_c = {fcs_slice_c[0], fcs_slice_c[1], fcs_slice_c[2], fcs_slice_c[3]};
    end

    // State register and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            nib_cnt_q  <= '0;
            fcs_q      <= '0;
            txen_q     <= 1'b0;
            txd_q      <= 4'h0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nib_cnt_q  <= nib_cnt_d;
            fcs_q      <= fcs_d;
            txen_q     <= txen_d;
            txd_q      <= txd_d;
            underrun_q <= underrun_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nib_cnt_d  = nib_cnt_q;
        fcs_d      = fcs_q;
        txen_d     = 1'b0;
        txd_d      = 4'h0;
        underrun_d = 1'b0;
        crc_ena_c  = 1'b0;
        crc_data_c = 4'h0;

        unique case (state_q)
            S_IDLE: begin
                // Launch the first preamble nibble here so that back-to-back frames
                // are separated by exactly IFG_NIBBLES idle cycles on the wire.
                if (bus.IN_VALID) begin
                    txen_d  = 1'b1;
                    txd_d   = 4'h5;
                    cnt_d   = CNT_W'(1);
                    state_d = S_PREAMBLE;
                end
            end

            S_PREAMBLE: begin
                txen_d    = 1'b1;
                nib_cnt_d = '0;
                if (cnt_q == CNT_W'(PREAMBLE_NIBBLES)) begin
                    txd_d   = 4'hD;
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    txd_d = 4'h5;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (bus.IN_VALID) begin
                    txen_d     = 1'b1;
                    txd_d      = bus.IN_DATA;
                    crc_ena_c  = 1'b1;
                    crc_data_c = bus.IN_DATA;
                    nib_cnt_d  = nib_inc_c;
                    if (bus.IN_LAST) begin
                        cnt_d   = '0;
                        state_d = (nib_inc_c < NIB_W'(MIN_NIBBLES)) ? S_PAD : S_FCS;
                    end
                end else begin
                    // Starved mid-frame: abort without FCS, still honour the gap.
                    underrun_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_IFG;
                end
            end

            S_PAD: begin
                txen_d     = 1'b1;
                crc_ena_c  = 1'b1;
                nib_cnt_d  = nib_inc_c;
                if (nib_inc_c >= NIB_W'(MIN_NIBBLES)) begin
                    cnt_d   = '0;
                    state_d = S_FCS;
                end
            end

            S_FCS: begin
                txen_d = 1'b1;
                txd_d  = fcs_nib_c;
                if (cnt_q == '0) begin
                    fcs_d = bus.IN_CRC;
                end
                if (cnt_q == CNT_W'(FCS_NIBBLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IFG;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_IFG: begin
                if (cnt_q == CNT_W'(IFG_NIBBLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.OUT_READY    = (state_q == S_DATA);
    assign bus.OUT_TXEN     = txen_q;
    assign bus.OUT_TXD      = txd_q;
    assign bus.OUT_CRC_CLR  = (state_q == S_PREAMBLE);
    assign bus.OUT_CRC_ENA  = crc_ena_c;
    assign bus.OUT_CRC_DATA = crc_data_c;
    assign bus.OUT_BUSY     = (state_q != S_IDLE);
    assign bus.OUT_UNDERRUN = underrun_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer with a behavioural CRC-32 nibble calculator and a
// wire-level expectation queue built from the framing rules.
module tb_eth_tx_framer;

    localparam int unsigned MIN_NIB = 120;

    logic clk;
    logic rst;
    logic stub_en;
    logic [31:0] crc_reg;

    eth_tx_framer_if bus ();

    eth_tx_framer #(
        .PREAMBLE_NIBBLES (15),
        .MIN_NIBBLES      (120),
        .IFG_NIBBLES      (24)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MSB-first CRC-32 (poly 0x04C11DB7), nibble bit0 shifted in first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 4; i++) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ 32'h04C1_1DB7;
        end
        return r;
    endfunction

    function automatic logic [3:0] pat(input int i, input int mul, input int seed);
        return 4'(i * mul + seed);
    endfunction

    // External CRC calculator stand-in.
    always @(posedge clk) begin
        if (rst || bus.OUT_CRC_CLR) crc_reg <= 32'hFFFF_FFFF;
        else if (bus.OUT_CRC_ENA)  crc_reg <= crc_step(crc_reg, bus.OUT_CRC_DATA);
    end
    assign bus.IN_CRC = stub_en ? 32'h1234_5678 : ~crc_reg;

    int vectors = 0;
    int errors  = 0;

    logic [3:0] exp_q[$];
    logic [3:0] cur_burst[$];
    logic [3:0] last_burst[$];
    int burst_len = 0;
    int gap_len   = 0;
    int last_gap  = 0;
    int underrun_pulses = 0;
    bit check_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every TXEN-high nibble must be the next expected wire nibble.
    always @(negedge clk) begin
        if (check_on) begin
            if (bus.OUT_UNDERRUN) underrun_pulses++;
            if (bus.OUT_TXEN) begin
                if (exp_q.size() == 0) begin
                    chk("txen_unexpected", 32'(bus.OUT_TXEN), 32'd0);
                end else begin
                    chk("txd", 32'(bus.OUT_TXD), 32'(exp_q.pop_front()));
                end
                if (burst_len == 0) last_gap = gap_len;
                gap_len = 0;
                burst_len++;
                cur_burst.push_back(bus.OUT_TXD);
            end else begin
                chk("idle_txd", 32'(bus.OUT_TXD), 32'd0);
                if (burst_len > 0) begin
                    last_burst = cur_burst;
                    cur_burst.delete();
                end
                burst_len = 0;
                gap_len++;
            end
        end
    end

    // Expected wire image: preamble, SFD, payload, pad, FCS sent C[31] first.
    task automatic push_expected(input int n, input int mul, input int seed,
                                 input int drop_at, input bit stub);
        logic [31:0] crc;
        logic [31:0] c;
        logic [31:0] wb;
        int m;
        int total;
        for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        m   = (drop_at > 0) ? drop_at : n;
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < m; i++) begin
            exp_q.push_back(pat(i, mul, seed));
            crc = crc_step(crc, pat(i, mul, seed));
        end
        if (drop_at == 0) begin
            total = n;
            while (total < int'(MIN_NIB)) begin
                exp_q.push_back(4'h0);
                crc = crc_step(crc, 4'h0);
                total++;
            end
            c = stub ? 32'h1234_5678 : ~crc;
            for (int j = 0; j < 32; j++) wb[j] = c[31 - j];
            for (int k = 0; k < 8; k++) exp_q.push_back(wb[4*k +: 4]);
        end
    endtask

    task automatic drive_frame(input int n, input int mul, input int seed,
                               input int drop_at, input bit hold_valid);
        int idx;
        int guard;
        bit acc;
        idx   = 0;
        guard = 0;
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = pat(0, mul, seed);
        bus.IN_LAST  = (n == 1);
        while (idx < n && guard < 3000) begin
            @(negedge clk);
            acc = bus.OUT_READY && bus.IN_VALID;
            @(posedge clk);
            #1;
            guard++;
            if (acc) begin
                idx++;
                if (idx == drop_at) begin
                    bus.IN_VALID = 1'b0;
                    bus.IN_LAST  = 1'b0;
                    break;
                end
                if (idx < n) begin
                    bus.IN_DATA = pat(idx, mul, seed);
                    bus.IN_LAST = (idx == n - 1);
                end else begin
                    bus.IN_VALID = hold_valid;
                    bus.IN_DATA  = 4'h0;
                    bus.IN_LAST  = 1'b0;
                end
            end
        end
        if (guard >= 3000) chk("drive_timeout", 32'(idx), 32'(n));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((bus.OUT_BUSY || bus.OUT_TXEN) && n < 3000);
        if (n >= 3000) chk("idle_timeout", 32'(bus.OUT_BUSY), 32'd0);
    endtask

    function automatic logic [31:0] residue();
        logic [31:0] r;
        r = 32'hFFFF_FFFF;
        for (int i = 16; i < last_burst.size(); i++) r = crc_step(r, last_burst[i]);
        return r;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] lit[8];
        int n;
        int up0;
        lit = '{4'h8, 4'h4, 4'hC, 4'h2, 4'hA, 4'h6, 4'hE, 4'h1};

        rst = 1'b1;
        stub_en = 1'b0;
        bus.IN_VALID = 1'b0;
        bus.IN_DATA  = 4'h0;
        bus.IN_LAST  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_txen",    32'(bus.OUT_TXEN),     32'd0);
        chk("rst_txd",     32'(bus.OUT_TXD),      32'd0);
        chk("rst_busy",    32'(bus.OUT_BUSY),     32'd0);
        chk("rst_ready",   32'(bus.OUT_READY),    32'd0);
        chk("rst_underrun",32'(bus.OUT_UNDERRUN), 32'd0);
        chk("rst_crc_clr", 32'(bus.OUT_CRC_CLR),  32'd0);
        chk("rst_crc_ena", 32'(bus.OUT_CRC_ENA),  32'd0);
        check_on = 1'b1;
        @(posedge clk);
        #1;

        // 64-nibble padded frame
        push_expected(64, 1, 0, 0, 1'b0);
        drive_frame(64, 1, 0, 0, 1'b0);
        wait_idle();
        chk("pad_len",     32'(last_burst.size()), 32'd144);
        chk("pad_residue", residue(), 32'hC704_DD7B);

        // Stubbed CRC value, 120-nibble frame
        stub_en = 1'b1;
        push_expected(120, 3, 1, 0, 1'b1);
        drive_frame(120, 3, 1, 0, 1'b0);
        wait_idle();
        stub_en = 1'b0;
        chk("stub_len", 32'(last_burst.size()), 32'd144);
        if (last_burst.size() == 144) begin
            for (int k = 0; k < 8; k++) chk("stub_fcs_lit", 32'(last_burst[136 + k]), 32'(lit[k]));
        end

        // 200-nibble frame, no padding
        push_expected(200, 7, 3, 0, 1'b0);
        drive_frame(200, 7, 3, 0, 1'b0);
        wait_idle();
        chk("long_len",     32'(last_burst.size()), 32'd224);
        chk("long_residue", residue(), 32'hC704_DD7B);

        // Underrun on the 30th DATA cycle
        up0 = underrun_pulses;
        push_expected(64, 5, 2, 29, 1'b0);
        drive_frame(64, 5, 2, 29, 1'b0);
        @(posedge clk);
        #1;
        chk("ur_txen",  32'(bus.OUT_TXEN),     32'd0);
        chk("ur_pulse", 32'(bus.OUT_UNDERRUN), 32'd1);
        n = 0;
        while (bus.OUT_BUSY && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("ur_ifg_cycles", 32'(n), 32'd24);
        chk("ur_busy_end",   32'(bus.OUT_BUSY), 32'd0);
        chk("ur_len",        32'(last_burst.size()), 32'd45);
        chk("ur_pulses",     32'(underrun_pulses - up0), 32'd1);

        // Back-to-back frames with IN_VALID held
        push_expected(40, 1, 9, 0, 1'b0);
        push_expected(130, 11, 4, 0, 1'b0);
        drive_frame(40, 1, 9, 0, 1'b1);
        fork
            drive_frame(130, 11, 4, 0, 1'b0);
            begin
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!(bus.OUT_TXEN && burst_len == 0) && n < 2000);
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                chk("b2b_crc_clr", 32'(bus.OUT_CRC_CLR), 32'd1);
            end
        join
        chk("b2b_gap", 32'(last_gap), 32'd24);
        wait_idle();
        chk("b2b_len2",     32'(last_burst.size()), 32'd154);
        chk("b2b_residue2", residue(), 32'hC704_DD7B);

        // Reset during FCS nibble 3
        push_expected(120, 1, 6, 0, 1'b0);
        drive_frame(120, 1, 6, 0, 1'b0);
        n = 0;
        while (!(bus.OUT_TXEN && burst_len == 139) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("fcs3_reached", 32'(burst_len), 32'd139);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        chk("mid_rst_txen", 32'(bus.OUT_TXEN), 32'd0);
        chk("mid_rst_txd",  32'(bus.OUT_TXD),  32'd0);
        chk("mid_rst_busy", 32'(bus.OUT_BUSY), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_len", 32'(last_burst.size()), 32'd140);

        // Frame after the aborted one
        push_expected(64, 13, 7, 0, 1'b0);
        drive_frame(64, 13, 7, 0, 1'b0);
        wait_idle();
        chk("post_len",     32'(last_burst.size()), 32'd144);
        chk("post_residue", residue(), 32'hC704_DD7B);

        chk("exp_drained",    32'(exp_q.size()), 32'd0);
        chk("total_underrun", 32'(underrun_pulses), 32'd1);

        check_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
